// File: rtl/red_pkg.sv
// Shared definitions for the RED reduction sequencer: widths and FSM state encoding.
package red_pkg;

  localparam int unsigned RED_IN_W  = 16;
  localparam int unsigned RED_OUT_W = 32;
  localparam int unsigned RED_HI_W  = 20;

  typedef enum logic [2:0] {
    IDLE,
    S_AB,
    S_CD,
    S_LO,
    S_HI,
    DONE
  } red_state_e;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice; all carries are computed directly from g/p and cin.
module cla_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] carry;

  always_comb begin
    g = x & y;
    p = x ^ y;
    carry[0] = cin;
    carry[1] = g[0] | (p[0] & cin);
    carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    sum      = p ^ carry;
  end

endmodule

// File: rtl/red_add8.sv
// Shared 8-bit add stage for the RED sequencer: two CLA nibbles with the
// inter-nibble carry exposed for the high-nibble step.
module red_add8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       c4
);

  cla_4bit u_lo (
    .x    (x[3:0]),
    .y    (y[3:0]),
    .cin  (cin),
    .sum  (sum[3:0]),
    .cout (c4)
  );

  cla_4bit u_hi (
    .x    (x[7:4]),
    .y    (y[7:4]),
    .cin  (c4),
    .sum  (sum[7:4]),
    .cout (cout)
  );

endmodule

// File: rtl/red_seq.sv
// Multi-cycle RED sequencer: four add steps through one shared 8-bit adder,
// valid/ready handshake on operand and result sides.
module red_seq
  import red_pkg::*;
#(
  parameter bit ACCEPT_ON_DONE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RED_IN_W-1:0]  a,
  input  logic [RED_IN_W-1:0]  b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RED_OUT_W-1:0] c,
  output logic                 busy
);

  red_state_e state_q, state_d;

  logic [RED_IN_W-1:0] a_q, a_d;
  logic [RED_IN_W-1:0] b_q, b_d;
  logic [8:0]          ab_q, ab_d;
  logic [8:0]          cd_q, cd_d;
  logic                t2_q, t2_d;
  logic [11:0]         c_q, c_d;
  logic                t3_q, t3_d;

  logic [7:0] add_x;
  logic [7:0] add_y;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_c4;

  red_add8 u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .c4   (add_c4)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ab_d     = ab_q;
    cd_d     = cd_q;
    t2_d     = t2_q;
    c_d      = c_q;
    t3_d     = t3_q;
    add_x    = '0;
    add_y    = '0;
    add_cin  = 1'b0;
    in_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_AB;
        end
      end
      S_AB: begin
        add_x   = a_q[15:8];
        add_y   = a_q[7:0];
        ab_d    = {add_cout, add_sum};
        state_d = S_CD;
      end
      S_CD: begin
        add_x   = b_q[15:8];
        add_y   = b_q[7:0];
        cd_d    = {add_cout, add_sum};
        state_d = S_LO;
      end
      S_LO: begin
        add_x     = ab_q[7:0];
        add_y     = cd_q[7:0];
        c_d[7:0]  = add_sum;
        t2_d      = add_cout;
        state_d   = S_HI;
      end
      S_HI: begin
        // Upper nibble is zero, so the nibble carry is the sign-fill bit for c[31:12].
        add_x     = {4'b0000, {4{ab_q[8]}}};
        add_y     = {4'b0000, {4{cd_q[8]}}};
        add_cin   = t2_q;
        c_d[11:8] = add_sum[3:0];
        t3_d      = add_c4;
        state_d   = DONE;
      end
      DONE: begin
        in_ready = ACCEPT_ON_DONE && out_ready;
        if (out_ready) begin
          if (ACCEPT_ON_DONE && in_valid) begin
            a_d     = a;
            b_d     = b;
            state_d = S_AB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ab_q    <= '0;
      cd_q    <= '0;
      t2_q    <= 1'b0;
      c_q     <= '0;
      t3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ab_q    <= ab_d;
      cd_q    <= cd_d;
      t2_q    <= t2_d;
      c_q     <= c_d;
      t3_q    <= t3_d;
    end
  end

  always_comb begin
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    c         = out_valid ? {{RED_HI_W{t3_q}}, c_q} : '0;
  end

endmodule

// File: tb/tb_red_seq.sv
// Randomized scoreboard bench for red_seq, plus a directed pass on the ACCEPT_ON_DONE=0 variant.
module tb_red_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] c;

  logic        z_rst, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
  logic [15:0] z_a, z_b;
  logic [31:0] z_c;

  red_seq #(.ACCEPT_ON_DONE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  red_seq #(.ACCEPT_ON_DONE(1'b0)) dut_z (
    .clk       (clk),
    .rst       (z_rst),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .a         (z_a),
    .b         (z_b),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .c         (z_c),
    .busy      (z_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  bit          front_seen = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_rst   = 1'b0;
  logic [31:0] prev_c     = '0;

  // Reference RED result straight from the arithmetic definition.
  function automatic logic [31:0] red_ref(input logic [15:0] x, input logic [15:0] y);
    int ab, cd, lo, hi;
    logic [31:0] r;
    ab = int'(x[15:8]) + int'(x[7:0]);
    cd = int'(y[15:8]) + int'(y[7:0]);
    lo = (ab % 256) + (cd % 256);
    hi = (ab / 256) * 15 + (cd / 256) * 15 + lo / 256;
    r  = 32'(lo % 256) | 32'((hi % 16) * 256);
    if (hi >= 16) r = r | 32'hFFFFF000;
    return r;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples at negedge; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk32("rst_c", c, 32'h0);
    end
    if (rst) begin
      sb.delete();
      front_seen = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk1("in_ready", in_ready, !busy || (out_valid && out_ready));
      if (!out_valid) chk32("c_masked", c, 32'h0);
      if (prev_stall) begin
        chk1("stall_valid", out_valid, 1'b1);
        chk32("stall_c", c, prev_c);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got c=%h expected no result (cycle %0d)", c, cyc);
        end else begin
          if (!front_seen) begin
            chk32("latency", 32'(cyc), 32'(sb[0].due));
            front_seen = 1'b1;
          end
          if (out_ready) begin
            chk32("result", c, sb[0].res);
            void'(sb.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{res: red_ref(a, b), due: cyc + 5});
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait (bounded) for the accept edge, then scramble the operand bus.
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    bit ok = 1'b0;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles");
    end
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
    step();
  endtask

  task automatic wait_idle();
    repeat (8) step();
  endtask

  initial begin
    int busy_n;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    z_rst = 1'b1; z_in_valid = 1'b0; z_out_ready = 1'b1; z_a = '0; z_b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic op and busy duration.
    issue(16'h1234, 16'h5678);
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      busy_n += int'(busy);
    end
    chk32("busy_cycles", 32'(busy_n), 32'd5);
    step();
    issue(16'hFFFF, 16'hFFFF);
    wait_idle();
    issue(16'h8080, 16'h0000);
    wait_idle();

    // Backpressure with in_valid held and operands churning while busy.
    out_ready = 1'b0;
    issue(16'hABCD, 16'h1357);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      step();
    end
    out_ready = 1'b1;
    a = 16'h1234;
    b = 16'h5678;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("no_gap_busy", busy, 1'b1);
    chk1("no_gap_valid", out_valid, 1'b0);
    step();
    wait_idle();

    // Reset in S_LO.
    issue(16'hFFFF, 16'h0001);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(16'h1234, 16'h5678);
    wait_idle();

    // Reset in DONE with out_valid high.
    out_ready = 1'b0;
    issue(16'h9999, 16'h7777);
    wait_valid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    issue(16'h1234, 16'h5678);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       begin a = 16'hFFFF; b = 16'hFFFF; end
        1:       begin a = 16'h8080; b = 16'h8080; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();
    chk32("drain", 32'(sb.size()), 32'd0);

    // ACCEPT_ON_DONE=0: one idle cycle before the next accept.
    z_rst = 1'b0;
    step();
    @(negedge clk);
    chk1("z_rst_ready", z_in_ready, 1'b1);
    chk1("z_rst_valid", z_out_valid, 1'b0);
    step();
    z_a = 16'h8080; z_b = 16'h0000; z_in_valid = 1'b1; z_out_ready = 1'b0;
    step();
    z_in_valid = 1'b0;
    z_a = 16'h5555; z_b = 16'hAAAA;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = z_out_valid;
    end
    chk1("z_valid", z_out_valid, 1'b1);
    chk32("z_result", z_c, red_ref(16'h8080, 16'h0000));
    repeat (3) step();
    z_in_valid = 1'b1; z_a = 16'h1234; z_b = 16'h5678; z_out_ready = 1'b1;
    @(negedge clk);
    chk1("z_done_ready", z_in_ready, 1'b0);
    step();
    @(negedge clk);
    chk1("z_idle_busy", z_busy, 1'b0);
    chk1("z_idle_valid", z_out_valid, 1'b0);
    chk1("z_idle_ready", z_in_ready, 1'b1);
    chk32("z_idle_c", z_c, 32'h0);
    step();
    z_in_valid = 1'b0;
    @(negedge clk);
    chk1("z_accept_busy", z_busy, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = z_out_valid;
    end
    chk32("z_result2", z_c, red_ref(16'h1234, 16'h5678));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
